// File: rtl/alu_req_arbiter_if.sv
// Signal bundle between the requesting engines, the arbiter and the serial-command ALU.
// The arbiter connects through the slave modport; the environment drives through master.
interface alu_req_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [2*NUM_REQ-1:0]          req_op;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_result;
    logic                          rsp_overflow;
    logic                          rsp_timeout;
    logic                          busy;
    logic                          alu_opcode_valid;
    logic                          alu_opcode;
    logic [DATA_WIDTH-1:0]         alu_data;
    logic                          alu_done;
    logic [DATA_WIDTH-1:0]         alu_result;
    logic                          alu_overflow;

    modport slave (
        input  req, req_op, req_a, req_b, alu_done, alu_result, alu_overflow,
        output gnt, rsp_valid, rsp_result, rsp_overflow, rsp_timeout, busy,
               alu_opcode_valid, alu_opcode, alu_data
    );

    modport master (
        output req, req_op, req_a, req_b, alu_done, alu_result, alu_overflow,
        input  gnt, rsp_valid, rsp_result, rsp_overflow, rsp_timeout, busy,
               alu_opcode_valid, alu_opcode, alu_data
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that serialises one request at a time into the ALU's three-cycle
// command protocol, waits for alu_done (or the watchdog) and returns the result.
module alu_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_req_arbiter_if.slave bus
);
    localparam int WW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, SEND0, SEND1, SEND2, WAIT, RESP} state_e;

    state_e                state_q;
    logic [WW-1:0]         ptr_q, win_q, win_d;
    logic [WW:0]           idx;
    logic                  found_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, b_q, a_d, b_d;
    logic [CW-1:0]         cnt_q;
    logic [NUM_REQ-1:0]    gnt_q, rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_result_q, alu_data_q;
    logic                  rsp_overflow_q, rsp_timeout_q, busy_q;
    logic                  alu_opcode_valid_q, alu_opcode_q;

    // Rotating search from ptr; idx is one bit wider so ptr+j never wraps before the subtract.
    always_comb begin
        found_d = 1'b0;
        win_d   = '0;
        idx     = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = {1'b0, ptr_q} + (WW+1)'(j);
            if (idx >= (WW+1)'(NUM_REQ)) idx = idx - (WW+1)'(NUM_REQ);
            if (!found_d && bus.req[idx[WW-1:0]]) begin
                found_d = 1'b1;
                win_d   = idx[WW-1:0];
            end
        end
        op_d = '0;
        a_d  = '0;
        b_d  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_d == WW'(i)) begin
                op_d = bus.req_op[2*i +: 2];
                a_d  = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
                b_d  = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Outputs are loaded on the transition into the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            ptr_q              <= '0;
            win_q              <= '0;
            op_q               <= '0;
            a_q                <= '0;
            b_q                <= '0;
            cnt_q              <= '0;
            gnt_q              <= '0;
            rsp_valid_q        <= '0;
            rsp_result_q       <= '0;
            rsp_overflow_q     <= 1'b0;
            rsp_timeout_q      <= 1'b0;
            busy_q             <= 1'b0;
            alu_opcode_valid_q <= 1'b0;
            alu_opcode_q       <= 1'b0;
            alu_data_q         <= '0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        win_q              <= win_d;
                        op_q               <= op_d;
                        a_q                <= a_d;
                        b_q                <= b_d;
                        gnt_q              <= NUM_REQ'(1) << win_d;
                        busy_q             <= 1'b1;
                        alu_opcode_valid_q <= 1'b1;
                        alu_opcode_q       <= op_d[0];
                        alu_data_q         <= a_d;
                        state_q            <= SEND0;
                    end
                end
                SEND0: begin
                    alu_opcode_q <= op_q[1];
                    alu_data_q   <= b_q;
                    state_q      <= SEND1;
                end
                SEND1: begin
                    alu_opcode_q <= 1'b0;
                    alu_data_q   <= '0;
                    state_q      <= SEND2;
                end
                SEND2: begin
                    alu_opcode_valid_q <= 1'b0;
                    cnt_q              <= '0;
                    state_q            <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (bus.alu_done) begin
                        rsp_result_q   <= bus.alu_result;
                        rsp_overflow_q <= bus.alu_overflow;
                        rsp_timeout_q  <= 1'b0;
                        rsp_valid_q    <= NUM_REQ'(1) << win_q;
                        state_q        <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT-1)) begin
                        rsp_result_q   <= '0;
                        rsp_overflow_q <= 1'b0;
                        rsp_timeout_q  <= 1'b1;
                        rsp_valid_q    <= NUM_REQ'(1) << win_q;
                        state_q        <= RESP;
                    end
                end
                RESP: begin
                    ptr_q   <= (win_q == WW'(NUM_REQ-1)) ? '0 : win_q + WW'(1);
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt              = gnt_q;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_result       = rsp_result_q;
    assign bus.rsp_overflow     = rsp_overflow_q;
    assign bus.rsp_timeout      = rsp_timeout_q;
    assign bus.busy             = busy_q;
    assign bus.alu_opcode_valid = alu_opcode_valid_q;
    assign bus.alu_opcode       = alu_opcode_q;
    assign bus.alu_data         = alu_data_q;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Random requesters and ALU against a transaction-timeline model: each grant predicts its
// command cycles, grant window and response cycle from the IDLE sampling cycle.
module tb_alu_req_arbiter;
    localparam int N = 4, DW = 8, T = 16, NCYC = 6000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_req_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus();
    alu_req_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_chk = 0, n_fail = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Requester-side state and the single in-flight transaction of the model.
    bit            pend[N], rq[N];
    logic [1:0]    op_r[N];
    logic [DW-1:0] a_r[N], b_r[N];
    bit            act;
    int            t0, win, resp, d, ptr_m, idle_at;
    logic [1:0]    t_op;
    logic [DW-1:0] t_a, t_b, t_res, e_res;
    bit            t_ovf, t_to, e_ovf, e_to;
    int            n_to, n_tie, n_rst;

    initial begin
        int            k, sel;
        bit            rst_now, real_done;
        logic [N-1:0]  eg, erv, rqv;
        logic          eaov, eaop, ebusy;
        logic [DW-1:0] ead;

        reset = 1'b1;
        bus.req = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        bus.alu_done = 1'b0; bus.alu_result = '0; bus.alu_overflow = 1'b0;
        for (int i = 0; i < N; i++) begin pend[i] = 0; rq[i] = 0; op_r[i] = '0; a_r[i] = '0; b_r[i] = '0; end
        act = 0; ptr_m = 0; idle_at = 0; e_res = '0; e_ovf = 0; e_to = 0;
        t0 = 0; win = 0; resp = 0; d = 0; n_to = 0; n_tie = 0; n_rst = 0;
        repeat (2) @(posedge clk);
        #1;

        while (cyc < NCYC) begin
            eg = '0; erv = '0; eaov = 0; eaop = 0; ead = '0; ebusy = 0;
            if (act) begin
                k = cyc - t0;
                if (k >= 1 && cyc <= resp) begin eg = N'(1) << win; ebusy = 1; end
                if (k >= 1 && k <= 3) eaov = 1;
                if (k == 1) begin eaop = t_op[0]; ead = t_a; end
                if (k == 2) begin eaop = t_op[1]; ead = t_b; end
                if (cyc == resp) begin
                    erv = N'(1) << win; e_res = t_res; e_ovf = t_ovf; e_to = t_to;
                end
            end
            chk("gnt",       32'(bus.gnt), 32'(eg));
            chk("busy",      32'(bus.busy), 32'(ebusy));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(erv));
            chk("rsp_result",   32'(bus.rsp_result), 32'(e_res));
            chk("rsp_overflow", 32'(bus.rsp_overflow), 32'(e_ovf));
            chk("rsp_timeout",  32'(bus.rsp_timeout), 32'(e_to));
            chk("alu_opcode_valid", 32'(bus.alu_opcode_valid), 32'(eaov));
            chk("alu_opcode",       32'(bus.alu_opcode), 32'(eaop));
            chk("alu_data",         32'(bus.alu_data), 32'(ead));

            if (act && cyc == resp) begin
                pend[win] = 0; rq[win] = 0; act = 0;
                ptr_m = (win + 1) % N; idle_at = cyc + 1;
            end

            rst_now = act && cyc >= t0 + 4 && cyc < resp && ($urandom % 60 == 0);

            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    rq[i] = 0;
                    if ($urandom % 4 == 0) begin
                        pend[i] = 1; rq[i] = 1;
                        op_r[i] = 2'($urandom); a_r[i] = DW'($urandom); b_r[i] = DW'($urandom);
                    end
                end else if (act && i == win && cyc > t0) begin
                    // Winner may drop req mid-command or disturb its operands; both are ignored.
                    if (cyc <= t0 + 3 && $urandom % 8 == 0) rq[i] = 0;
                    if ($urandom % 4 == 0) begin
                        op_r[i] = 2'($urandom); a_r[i] = DW'($urandom); b_r[i] = DW'($urandom);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                rqv[i] = rq[i];
                bus.req_op[2*i +: 2]  = op_r[i];
                bus.req_a[i*DW +: DW] = a_r[i];
                bus.req_b[i*DW +: DW] = b_r[i];
            end
            bus.req = rqv;

            if (rst_now) begin
                reset = 1'b1; n_rst++;
                act = 0; ptr_m = 0; idle_at = cyc + 1;
                e_res = '0; e_ovf = 0; e_to = 0;
                for (int i = 0; i < N; i++) pend[i] = 0;
            end else begin
                reset = 1'b0;
                if (!act && cyc >= idle_at && rqv != '0) begin
                    win = -1;
                    for (int j = 0; j < N; j++)
                        if (win < 0 && rq[(ptr_m + j) % N]) win = (ptr_m + j) % N;
                    act = 1; t0 = cyc;
                    t_op = op_r[win]; t_a = a_r[win]; t_b = b_r[win];
                    sel = int'($urandom % 20);
                    if (sel < 3)       d = -1;
                    else if (sel < 5)  d = T - 1;
                    else if (sel < 12) d = int'($urandom % 3);
                    else               d = int'($urandom % T);
                    if (d < 0) begin
                        resp = t0 + 4 + T; t_res = '0; t_ovf = 0; t_to = 1; n_to++;
                    end else begin
                        resp = t0 + 5 + d; t_res = DW'($urandom); t_ovf = 1'($urandom); t_to = 0;
                        if (d == T - 1) n_tie++;
                    end
                end
            end

            real_done = act && d >= 0 && cyc == t0 + 4 + d;
            if (real_done) begin
                bus.alu_done = 1'b1; bus.alu_result = t_res; bus.alu_overflow = t_ovf;
            end else begin
                bus.alu_done = (!act || cyc < t0 + 4 || cyc >= resp) && ($urandom % 5 == 0);
                bus.alu_result = DW'($urandom); bus.alu_overflow = 1'($urandom);
            end

            @(posedge clk);
            #1;
            cyc++;
        end

        chk("saw_timeout", 32'(n_to > 0), 32'd1);
        chk("saw_tie",     32'(n_tie > 0), 32'd1);
        chk("saw_reset",   32'(n_rst > 0), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule
